// File: rtl/huil_pkg.sv
// Shared types and constants for the cry-volume measurement sequencer.
package huil_pkg;

  typedef enum logic [1:0] {
    QUIET,
    ARMING,
    CRYING,
    COOLING
  } huil_state_t;

  localparam int                    HUIL_VOL_W   = 8;
  localparam logic [HUIL_VOL_W-1:0] HUIL_SAT_VOL = 8'hFF;

  function automatic int huil_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/huil_meet_sequencer_if.sv
// DSP sample input and window result bundle; piek exists only with HUIL_PEAK_EN.
interface huil_meet_sequencer_if;
  import huil_pkg::*;

  logic [HUIL_VOL_W-1:0] dsp_data;
  logic                  dsp_ready;
  logic [HUIL_VOL_W-1:0] volume;
  logic                  volume_valid;
  logic                  window_clear;
  logic                  huil_actief;
`ifdef HUIL_PEAK_EN
  logic [HUIL_VOL_W-1:0] piek;

  modport master (output dsp_data, dsp_ready,
                  input  volume, volume_valid, window_clear, huil_actief, piek);
  modport slave  (input  dsp_data, dsp_ready,
                  output volume, volume_valid, window_clear, huil_actief, piek);
`else
  modport master (output dsp_data, dsp_ready,
                  input  volume, volume_valid, window_clear, huil_actief);
  modport slave  (input  dsp_data, dsp_ready,
                  output volume, volume_valid, window_clear, huil_actief);
`endif

endinterface

// File: rtl/huil_window_timer.sv
// Free-running measurement window counter; boundary is high in the last cycle of each window.
module huil_window_timer #(
  parameter int WINDOW_CYCLES = 1000000
) (
  input  logic clk,
  input  logic resetmore,
  input  logic enable,
  output logic boundary
);

  localparam int               CNT_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WINDOW_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: state registers use non-blocking assignments and an asynchronous reset
  // in the sensitivity list, so reset acts without waiting for a clock edge.
  always_ff @(posedge clk or posedge resetmore) begin
    if (resetmore)                  cnt <= '0;
    else if (!enable || cnt == LAST) cnt <= '0;
    else                            cnt <= cnt + CNT_W'(1);
  end

  assign boundary = enable && (cnt == LAST);

endmodule

// File: rtl/huil_meet_sequencer.sv
// Cry-volume measurement: per-window sample accumulation, volume publication and
// hysteresis crying detection. Define HUIL_PEAK_EN to add the per-window peak output.
module huil_meet_sequencer
  import huil_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1000000,
  parameter int ACC_W         = 14,
  parameter int SHIFT         = 6,
  parameter int ON_WINDOWS    = 3,
  parameter int OFF_WINDOWS   = 5
) (
  input  logic                  clk,
  input  logic                  resetmore,
  input  logic                  enable,
  input  logic [HUIL_VOL_W-1:0] thr_on,
  input  logic [HUIL_VOL_W-1:0] thr_off,
  huil_meet_sequencer_if.slave  bus
);

  localparam int                  STREAK_W = $clog2(huil_max(ON_WINDOWS, OFF_WINDOWS) + 1);
  localparam logic [STREAK_W-1:0] ON_CNT   = STREAK_W'(ON_WINDOWS);
  localparam logic [STREAK_W-1:0] OFF_CNT  = STREAK_W'(OFF_WINDOWS);

  logic                  rdy_q, accept, boundary;
  logic [ACC_W-1:0]      acc, acc_sat, shifted;
  logic [ACC_W:0]        sum;
  logic [HUIL_VOL_W-1:0] volume, vol_next;
  logic                  volume_valid, window_clear, huil_actief;
  logic                  loud, quiet;
  huil_state_t           state;
  logic [STREAK_W-1:0]   streak, streak_inc;

  // Only a rising edge of the ready level counts, so a held level is one sample.
  assign accept = bus.dsp_ready && !rdy_q && enable;

  huil_window_timer #(.WINDOW_CYCLES(WINDOW_CYCLES)) u_timer (
    .clk      (clk),
    .resetmore(resetmore),
    .enable   (enable),
    .boundary (boundary)
  );

  // NOTE: every signal below is assigned on every pass, so no latch can be inferred.
  always_comb begin
    sum        = {1'b0, acc} + {{(ACC_W + 1 - HUIL_VOL_W){1'b0}}, bus.dsp_data};
    acc_sat    = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    shifted    = acc >> SHIFT;
    vol_next   = (shifted > ACC_W'(HUIL_SAT_VOL)) ? HUIL_SAT_VOL : shifted[HUIL_VOL_W-1:0];
    streak_inc = streak + STREAK_W'(1);
    loud       = (volume >= thr_on);
    quiet      = (volume < thr_off);
  end

  // A sample landing on the boundary cycle seeds the next window instead of this one.
  always_ff @(posedge clk or posedge resetmore) begin
    if (resetmore) begin
      rdy_q        <= 1'b0;
      acc          <= '0;
      volume       <= '0;
      volume_valid <= 1'b0;
      window_clear <= 1'b0;
    end else begin
      rdy_q        <= bus.dsp_ready;
      volume_valid <= boundary;
      window_clear <= boundary;
      if (!enable) begin
        acc <= '0;
      end else if (boundary) begin
        acc    <= accept ? ACC_W'(bus.dsp_data) : '0;
        volume <= vol_next;
      end else if (accept) begin
        acc <= acc_sat;
      end
    end
  end

  always_ff @(posedge clk or posedge resetmore) begin
    if (resetmore) begin
      state       <= QUIET;
      streak      <= '0;
      huil_actief <= 1'b0;
    end else if (!enable) begin
      state       <= QUIET;
      streak      <= '0;
      huil_actief <= 1'b0;
    end else if (volume_valid) begin
      case (state)
        QUIET: if (loud) begin
          if (ON_CNT == STREAK_W'(1)) begin
            state <= CRYING; streak <= '0; huil_actief <= 1'b1;
          end else begin
            state <= ARMING; streak <= STREAK_W'(1);
          end
        end
        ARMING: if (!loud) begin
          state <= QUIET; streak <= '0;
        end else if (streak_inc == ON_CNT) begin
          state <= CRYING; streak <= '0; huil_actief <= 1'b1;
        end else begin
          streak <= streak_inc;
        end
        CRYING: if (quiet) begin
          if (OFF_CNT == STREAK_W'(1)) begin
            state <= QUIET; streak <= '0; huil_actief <= 1'b0;
          end else begin
            state <= COOLING; streak <= STREAK_W'(1);
          end
        end
        COOLING: if (!quiet) begin
          state <= CRYING; streak <= '0;
        end else if (streak_inc == OFF_CNT) begin
          state <= QUIET; streak <= '0; huil_actief <= 1'b0;
        end else begin
          streak <= streak_inc;
        end
        default: begin
          state <= QUIET; streak <= '0; huil_actief <= 1'b0;
        end
      endcase
    end
  end

`ifdef HUIL_PEAK_EN
  logic [HUIL_VOL_W-1:0] peak_acc, piek;

  always_ff @(posedge clk or posedge resetmore) begin
    if (resetmore) begin
      peak_acc <= '0;
      piek     <= '0;
    end else if (!enable) begin
      peak_acc <= '0;
    end else if (boundary) begin
      piek     <= peak_acc;
      peak_acc <= accept ? bus.dsp_data : '0;
    end else if (accept && bus.dsp_data > peak_acc) begin
      peak_acc <= bus.dsp_data;
    end
  end

  assign bus.piek = piek;
`endif

  assign bus.volume       = volume;
  assign bus.volume_valid = volume_valid;
  assign bus.window_clear = window_clear;
  assign bus.huil_actief  = huil_actief;

endmodule

// File: doc/huil_meet_sequencer.md
Name: huil_meet_sequencer

Overview:
Controls the cry-volume measurement.
- Defines fixed measurement windows in `clk` cycles.
- Accepts DSP samples on a synchronous `dsp_ready` handshake and accumulates them per window.
- Publishes an 8-bit window volume with a valid strobe.
- Runs a hysteresis state machine that decides whether the baby is crying.
- Sits between the DSP front end and the rocking/response logic, and replaces ad-hoc window resets driven by a slow clock.

Parameters:
- WINDOW_CYCLES, 1000000, `clk` cycles per measurement window (≥2).
- ACC_W, 14, accumulator width in bits.
- SHIFT, 6, right shift applied to the accumulator to form the volume.
- ON_WINDOWS, 3, consecutive loud windows required to enter CRYING (≥1).
- OFF_WINDOWS, 5, consecutive quiet windows required to leave crying (≥1).

Ports:
- clk, in, 1, system clock.
- resetmore, in, 1, reset: asynchronous, active-high.
- enable, in, 1, measurement enable.
- dsp_data, in, 8, DSP sample.
- dsp_ready, in, 1, DSP sample-ready level; sampled in the `clk` domain.
- thr_on, in, 8, loud threshold.
- thr_off, in, 8, quiet threshold.
- volume, out, 8, last completed window volume.
- volume_valid, out, 1, one-cycle strobe: `volume` has been updated.
- window_clear, out, 1, one-cycle strobe at each window boundary.
- huil_actief, out, 1, high while crying is detected.

Behaviour:
- Reset (`resetmore`=1, asynchronous):
  - All outputs 0.
  - Accumulator, window counter, streak counter and `dsp_ready` history cleared.
  - FSM forced to QUIET.
- Sample acceptance:
  - `rdy_q` is the registered `dsp_ready`.
  - A sample is accepted when `dsp_ready`=1, `rdy_q`=0 and `enable`=1.
  - Exactly one sample is accepted per rising edge.
  - `dsp_data` is taken in the same cycle the edge is detected.
- Accumulator:
  - Unsigned, ACC_W bits.
  - `acc` + sample saturates at 2^ACC_W−1; it never wraps.
- Window counter:
  - Counts 0..WINDOW_CYCLES−1 while `enable`=1.
  - The boundary is the cycle in which the count is WINDOW_CYCLES−1. At the next edge:
    - `volume` <= `acc`[SHIFT+7:SHIFT]. If `acc`>>SHIFT exceeds 255, `volume` = 255.
    - `volume_valid` and `window_clear` are high for exactly that one cycle.
    - The counter returns to 0.
  - Volume latency: 1 cycle after the boundary cycle.
- Sample coinciding with the boundary:
  - It belongs to the new window: `acc` <= sample, not 0.
  - It is excluded from the published volume.
- `enable`=0:
  - Counter and `acc` are held at 0, and no strobes are issued.
  - FSM returns to QUIET and the streak counter is cleared.
  - `volume` keeps its last value.
- Re-enable: the first window is a full WINDOW_CYCLES long.
- FSM: states QUIET, ARMING, CRYING, COOLING. It is evaluated only in cycles where `volume_valid`=1, using the new `volume`.
  - QUIET:
    - `volume` ≥ `thr_on` → ARMING, streak=1.
    - If ON_WINDOWS=1, go directly to CRYING instead.
  - ARMING:
    - `volume` ≥ `thr_on` → streak+1; when streak reaches ON_WINDOWS → CRYING, streak=0.
    - Otherwise → QUIET, streak=0.
  - CRYING:
    - `volume` < `thr_off` → COOLING, streak=1.
    - If OFF_WINDOWS=1, go directly to QUIET instead.
  - COOLING:
    - `volume` < `thr_off` → streak+1; when streak reaches OFF_WINDOWS → QUIET.
    - Otherwise → CRYING, streak=0.
- `huil_actief`:
  - Registered; equals 1 when the state is CRYING or COOLING.
  - Updates in the same cycle as the state change.
- Threshold misconfiguration (`thr_off` > `thr_on`): still fully defined by the rules above; no special handling.
- Threshold changes: take effect at the next `volume_valid`.
- Streak counter: width $clog2(max(ON_WINDOWS,OFF_WINDOWS)+1).

Optional Feature:
- Macro: HUIL_PEAK_EN.
- With the macro defined:
  - Adds output port `piek` (8 bits): the maximum accepted sample in the last completed window.
  - `piek` is updated together with `volume`; a sample coinciding with the boundary seeds the new window's max.
  - `piek` resets to 0.
- Without the macro: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package `huil_pkg`:
  - State enum `huil_state_t` {QUIET, ARMING, CRYING, COOLING}.
  - Constants `HUIL_VOL_W`=8 and `HUIL_SAT_VOL`=8'hFF.
- Sub-module `huil_window_timer`:
  - Counter with `enable` input and one-cycle `boundary` output.
  - Parameterised by WINDOW_CYCLES.
  - Instantiated once.

Test Plan:
- Volume scaling: WINDOW_CYCLES=64, 10 ready pulses of `dsp_data`=128 → `volume`=20, one-cycle `volume_valid` and `window_clear`.
- Saturation: 200 pulses of 255 in one window → `acc` saturates at 16383, `volume`=255, no wrap.
- Boundary coincidence: `dsp_ready` held high for several cycles counts once; a pulse exactly on the boundary cycle → excluded from the current `volume`, next window starts at that sample.
- Hysteresis: `thr_on`=40, `thr_off`=20; window volumes 50,50,50 → `huil_actief`=1 after the 3rd strobe; 10,10,30 → stays 1 (COOLING→CRYING); 10×5 → 0.
- Enable drop and reset: `enable`=0 mid-window → no strobe, FSM QUIET, `volume` held; `resetmore` pulse mid-window → all outputs 0 immediately (asynchronous).
- HUIL_PEAK_EN build: samples 3,200,7 → `piek`=200 in the same cycle as `volume_valid`.
